// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Brief    : 4x4 keypad column scanner with press/release debounce, one-hot key out.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [15:0] key_onehot,
  output logic        key_valid,
  output logic        key_down
);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  localparam logic [15:0] c_scan_last = 16'(SCAN_DIV - 1);
  localparam logic [15:0] c_deb_last  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  c_no_rows   = 4'b1111;

  state_t      r_state;
  logic [3:0]  r_sync1;
  logic [3:0]  r_srows;
  logic [1:0]  r_col;
  logic [1:0]  r_row;
  logic [3:0]  r_pat;
  logic [15:0] r_div;
  logic [15:0] r_cnt;

  logic        w_one_low;
  logic [1:0]  w_row_idx;
  logic [1:0]  w_next_col;
  logic [3:0]  w_next_cols;

  // Only a single low row identifies a key unambiguously.
  always_comb begin
    w_one_low = 1'b0;
    w_row_idx = 2'd0;
    case (r_srows)
      4'b1110: begin w_one_low = 1'b1; w_row_idx = 2'd0; end
      4'b1101: begin w_one_low = 1'b1; w_row_idx = 2'd1; end
      4'b1011: begin w_one_low = 1'b1; w_row_idx = 2'd2; end
      4'b0111: begin w_one_low = 1'b1; w_row_idx = 2'd3; end
      default: begin w_one_low = 1'b0; w_row_idx = 2'd0; end
    endcase
  end

  assign w_next_col  = r_col + 2'd1;
  assign w_next_cols = ~(4'b0001 << w_next_col);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_SCAN;
      r_sync1    <= c_no_rows;
      r_srows    <= c_no_rows;
      r_col      <= 2'd0;
      cols       <= 4'b1110;
      r_row      <= 2'd0;
      r_pat      <= c_no_rows;
      r_div      <= 16'd0;
      r_cnt      <= 16'd0;
      key_onehot <= 16'd0;
      key_valid  <= 1'b0;
      key_down   <= 1'b0;
    end else begin
      r_sync1   <= rows;
      r_srows   <= r_sync1;
      key_valid <= 1'b0;
      case (r_state)
        S_SCAN: begin
          if (r_div == c_scan_last) begin
            r_div <= 16'd0;
            if (w_one_low) begin
              r_row   <= w_row_idx;
              r_pat   <= r_srows;
              r_cnt   <= 16'd0;
              r_state <= S_DEBOUNCE;
            end else begin
              r_col <= w_next_col;
              cols  <= w_next_cols;
            end
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        S_DEBOUNCE: begin
          if (r_srows == r_pat) begin
            if (r_cnt == c_deb_last) begin
              r_state    <= S_HELD;
              r_cnt      <= 16'd0;
              key_onehot <= 16'd1 << {r_row, r_col};
              key_valid  <= 1'b1;
              key_down   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end else begin
            // A bounce abandons this column; scanning picks up at the next one.
            r_state <= S_SCAN;
            r_cnt   <= 16'd0;
            r_div   <= 16'd0;
            r_col   <= w_next_col;
            cols    <= w_next_cols;
          end
        end
        S_HELD: begin
          if (r_srows == c_no_rows) begin
            r_state <= S_RELEASE;
            r_cnt   <= 16'd0;
          end
        end
        S_RELEASE: begin
          if (r_srows == c_no_rows) begin
            if (r_cnt == c_deb_last) begin
              r_state  <= S_SCAN;
              r_cnt    <= 16'd0;
              r_div    <= 16'd0;
              r_col    <= w_next_col;
              cols     <= w_next_cols;
              key_down <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end else begin
            r_state <= S_HELD;
            r_cnt   <= 16'd0;
          end
        end
        default: r_state <= S_SCAN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Brief    : Directed + randomized bench with a keypad model and a behavioural reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rows = 4'hF;
  logic [3:0]  cols;
  logic [15:0] key_onehot;
  logic        key_valid;
  logic        key_down;

  logic [15:0] pressed = 16'h0;
  logic [3:0]  noise = 4'h0;
  logic        cmp_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_valid = 0;

  // Reference state: scan position is expressed as elapsed time from a start column.
  int          m_mode = M_SCAN, m_base = 0, m_t = 0, m_col = 0, m_cnt = 0;
  logic [3:0]  m_s1 = 4'hF, m_s2 = 4'hF, m_pat = 4'hF;
  logic [15:0] m_key = 16'h0;
  logic        m_valid = 1'b0, m_down = 1'b0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key_onehot(key_onehot), .key_valid(key_valid), .key_down(key_down)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] keypad_rows(input logic [15:0] keys, input logic [3:0] drive);
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (keys[rr*4+cc] && !drive[cc]) r[rr] = 1'b0;
    return r;
  endfunction

  function automatic int row_of(input logic [3:0] pat);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (!pat[i]) r = i;
    return r;
  endfunction

  function automatic logic [3:0] model_cols();
    int c;
    c = (m_mode == M_SCAN) ? (m_base + m_t / SCAN_DIV) % 4 : m_col;
    return ~(4'b0001 << c);
  endfunction

  // Physical keypad: a pressed key shorts its row to the driven column.
  always @(negedge clk) rows = keypad_rows(pressed, cols) & ~noise;

  always @(posedge clk) begin : model
    int mode, base, t, col, cnt, cur;
    logic [3:0] pat;
    logic [15:0] key;
    logic valid, down;
    mode = m_mode; base = m_base; t = m_t; col = m_col; cnt = m_cnt;
    pat = m_pat; key = m_key; down = m_down; valid = 1'b0;
    if (!reset) begin
      mode = M_SCAN; base = 0; t = 0; col = 0; cnt = 0;
      pat = 4'hF; key = 16'h0; down = 1'b0;
      m_s1 <= 4'hF; m_s2 <= 4'hF;
    end else begin
      m_s1 <= rows; m_s2 <= m_s1;
      case (mode)
        M_SCAN: begin
          cur = (base + t / SCAN_DIV) % 4;
          if ((t % SCAN_DIV == SCAN_DIV - 1) && ($countones(~m_s2) == 1)) begin
            mode = M_DEB; col = cur; pat = m_s2; cnt = 0;
          end else t++;
        end
        M_DEB: begin
          if (m_s2 == pat) begin
            cnt++;
            if (cnt == DEB) begin
              mode = M_HELD; valid = 1'b1; down = 1'b1;
              key = 16'(1) << (row_of(pat) * 4 + col);
            end
          end else begin
            mode = M_SCAN; base = (col + 1) % 4; t = 0;
          end
        end
        M_HELD: if (m_s2 == 4'hF) begin mode = M_REL; cnt = 0; end
        default: begin
          if (m_s2 == 4'hF) begin
            cnt++;
            if (cnt == DEB) begin mode = M_SCAN; base = (col + 1) % 4; t = 0; down = 1'b0; end
          end else begin
            mode = M_HELD; cnt = 0;
          end
        end
      endcase
    end
    m_mode <= mode; m_base <= base; m_t <= t; m_col <= col; m_cnt <= cnt;
    m_pat <= pat; m_key <= key; m_valid <= valid; m_down <= down;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cols", {28'h0, cols}, {28'h0, model_cols()});
      chk("key_valid", {31'h0, key_valid}, {31'h0, m_valid});
      chk("key_down", {31'h0, key_down}, {31'h0, m_down});
      chk("key_onehot", {16'h0, key_onehot}, {16'h0, m_key});
      chk("onehot_legal", {31'h0, (key_onehot == 16'h0) || $onehot(key_onehot)}, 32'd1);
      chk("cols_one_low", $countones(~cols), 32'd1);
      if (key_valid) n_valid++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int v0, hold_left, sel, waited;
    logic [3:0] exp_c;
    reset = 1'b0;
    tick();
    cmp_en = 1'b1;
    repeat (2) tick();
    reset = 1'b1;

    // Idle scan: column walks every SCAN_DIV cycles from column 0
    for (int k = 0; k < 40; k++) begin
      exp_c = ~(4'b0001 << ((k / 4) % 4));
      chk("idle_cols", {28'h0, cols}, {28'h0, exp_c});
      tick();
    end
    chk("idle_onehot", {16'h0, key_onehot}, 32'h0);
    chk("idle_valid_count", n_valid, 0);

    // Key row 2 / col 1
    v0 = n_valid;
    pressed = 16'h0200;
    repeat (40) tick();
    chk("k21_onehot", {16'h0, key_onehot}, 32'h0200);
    chk("k21_down", {31'h0, key_down}, 32'd1);
    chk("k21_cols", {28'h0, cols}, 32'hD);
    chk("k21_valid_count", n_valid - v0, 1);
    pressed = 16'h0;
    repeat (30) tick();

    // Bouncing key row 0 / col 3
    v0 = n_valid;
    for (int i = 0; i < 30; i++) begin
      pressed = (i % 2 == 0) ? 16'h0008 : 16'h0000;
      repeat (3) tick();
    end
    chk("bounce_valid_count", n_valid - v0, 0);
    chk("bounce_onehot", {16'h0, key_onehot}, 32'h0200);
    pressed = 16'h0;
    repeat (10) tick();

    // Row 3 / col 3 held, second key on row 0 ignored, then both released
    v0 = n_valid;
    pressed = 16'h8000;
    repeat (40) tick();
    pressed = 16'h8008;
    repeat (10) tick();
    chk("k33_onehot", {16'h0, key_onehot}, 32'h8000);
    chk("k33_valid_count", n_valid - v0, 1);
    pressed = 16'h0;
    repeat (10) tick();
    chk("k33_down_still", {31'h0, key_down}, 32'd1);
    tick();
    chk("k33_down_fall", {31'h0, key_down}, 32'd0);
    chk("k33_rescan_cols", {28'h0, cols}, 32'hE);
    repeat (10) tick();

    // Two rows low on col 2
    v0 = n_valid;
    pressed = 16'h0044;
    repeat (40) tick();
    chk("multi_valid_count", n_valid - v0, 0);
    chk("multi_onehot", {16'h0, key_onehot}, 32'h8000);
    pressed = 16'h0;
    repeat (5) tick();

    // Reset four cycles into debounce
    v0 = n_valid;
    pressed = 16'h0010;
    waited = 0;
    while (m_mode != M_DEB && waited < 100) begin tick(); waited++; end
    chk("deb_reached", {31'h0, m_mode == M_DEB}, 32'd1);
    repeat (4) tick();
    reset = 1'b0;
    pressed = 16'h0;
    tick();
    chk("rst_cols", {28'h0, cols}, 32'hE);
    chk("rst_valid", {31'h0, key_valid}, 32'd0);
    chk("rst_onehot", {16'h0, key_onehot}, 32'h0);
    reset = 1'b1;
    repeat (20) tick();
    chk("rst_valid_count", n_valid - v0, 0);

    // Randomized keypad activity with glitches and occasional resets
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        sel = $urandom_range(0, 99);
        if (sel < 45) pressed = 16'h0;
        else if (sel < 85) pressed = 16'(1) << $urandom_range(0, 15);
        else pressed = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        hold_left = $urandom_range(3, 60);
      end
      hold_left--;
      noise = ($urandom_range(0, 49) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      reset = ($urandom_range(0, 799) != 0);
      tick();
    end
    reset = 1'b1;
    noise = 4'h0;
    pressed = 16'h0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
